// File: rtl/mpc_sdiv_35s_13ns_21s_seq.sv
// mpc_sdiv_35s_13ns_21s_seq
//   Sequential divider: 35-bit signed dividend by 13-bit unsigned divisor.
//   Produces a 21-bit signed quotient, truncated toward zero and saturated.
//   It undoes the 21s x 13ns DSP product path, so MPC accumulator values can be
//   rescaled back to state/control width. One quotient bit per ce-enabled cycle.
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset (wins over ce)
//   ce            clock enable; every flop holds when low
//   in_valid/in_ready, a, b           operand handshake (in_ready = IDLE)
//   out_valid/out_ready, q, ovf, div_err   result handshake, held in DONE
//   rem           signed remainder, only when MPC_DIV_REMAINDER_EN is defined
// Configuration macro: MPC_DIV_REMAINDER_EN
module mpc_sdiv_35s_13ns_21s_seq #(
  parameter int DIVIDEND_W = 35,
  parameter int DIVISOR_W  = 13,
  parameter int QUOTIENT_W = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIVIDEND_W-1:0] a,
  input  logic        [DIVISOR_W-1:0]  b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [QUOTIENT_W-1:0] q,
  output logic                         ovf,
  output logic                         div_err
`ifdef MPC_DIV_REMAINDER_EN
  ,
  output logic signed [DIVISOR_W:0]    rem
`endif
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DIVIDEND_W - 1);
  localparam logic [QUOTIENT_W-1:0] Q_MAX    = {1'b0, {(QUOTIENT_W-1){1'b1}}};
  localparam logic [QUOTIENT_W-1:0] Q_MIN    = {1'b1, {(QUOTIENT_W-1){1'b0}}};
  // Largest magnitudes representable for positive / negative results.
  localparam logic [DIVIDEND_W-1:0] MAG_POS_MAX = DIVIDEND_W'(Q_MAX);
  localparam logic [DIVIDEND_W-1:0] MAG_NEG_MAX = DIVIDEND_W'(Q_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB first; quotient bits shift in at the LSB.
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  // Partial remainder is always < divisor, so DIVISOR_W bits suffice between steps.
  logic [DIVISOR_W-1:0]    prem_q, prem_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic                    neg_q, neg_d;
  logic                    zero_q, zero_d;
  logic [QUOTIENT_W-1:0]   q_q, q_d;
  logic                    ovf_q, ovf_d;
  logic                    err_q, err_d;
`ifdef MPC_DIV_REMAINDER_EN
  logic [DIVISOR_W:0]      rem_q, rem_d;
`endif

  logic                    accept_s;
  logic [DIVIDEND_W-1:0]   a_mag_s;
  logic [DIVISOR_W:0]      prem_shift_s;
  logic                    ge_s;

  // State and datapath registers; ce freezes everything, reset overrides ce.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      prem_q  <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef MPC_DIV_REMAINDER_EN
      rem_q   <= '0;
`endif
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      prem_q  <= prem_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
`ifdef MPC_DIV_REMAINDER_EN
      rem_q   <= rem_d;
`endif
    end else begin
      state_q <= state_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = (b == '0) ? S_FIX : S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Datapath: operand capture, restoring iteration, sign fix-up and saturation.
  always_comb begin
    accept_s     = in_valid & (state_q == S_IDLE);
    a_mag_s      = a[DIVIDEND_W-1] ? (~a + DIVIDEND_W'(1)) : a;
    prem_shift_s = {prem_q, dvd_q[DIVIDEND_W-1]};
    ge_s         = (prem_shift_s >= {1'b0, dvs_q});
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    prem_d = prem_q;
    dvs_d  = dvs_q;
    neg_d  = neg_q;
    zero_d = zero_q;
    q_d    = q_q;
    ovf_d  = ovf_q;
    err_d  = err_q;
`ifdef MPC_DIV_REMAINDER_EN
    rem_d  = rem_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          dvd_d  = a_mag_s;
          neg_d  = a[DIVIDEND_W-1];
          dvs_d  = b;
          zero_d = (b == '0);
          prem_d = '0;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q;
        end
      end
      S_CALC: begin
        if (ge_s) begin
          prem_d = DIVISOR_W'(prem_shift_s - {1'b0, dvs_q});
        end else begin
          prem_d = DIVISOR_W'(prem_shift_s);
        end
        dvd_d = {dvd_q[DIVIDEND_W-2:0], ge_s};
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_FIX: begin
        if (zero_q) begin
          q_d   = neg_q ? Q_MIN : Q_MAX;
          ovf_d = 1'b1;
          err_d = 1'b1;
        end else if (!neg_q && (dvd_q > MAG_POS_MAX)) begin
          q_d   = Q_MAX;
          ovf_d = 1'b1;
          err_d = 1'b0;
        end else if (neg_q && (dvd_q > MAG_NEG_MAX)) begin
          q_d   = Q_MIN;
          ovf_d = 1'b1;
          err_d = 1'b0;
        end else begin
          // Magnitude 2^(QW-1) with negative sign negates to Q_MIN exactly.
          q_d   = neg_q ? (~dvd_q[QUOTIENT_W-1:0] + QUOTIENT_W'(1))
                        : dvd_q[QUOTIENT_W-1:0];
          ovf_d = 1'b0;
          err_d = 1'b0;
        end
`ifdef MPC_DIV_REMAINDER_EN
        if (zero_q) begin
          rem_d = '0;
        end else if (neg_q) begin
          rem_d = ~{1'b0, prem_q} + (DIVISOR_W+1)'(1);
        end else begin
          rem_d = {1'b0, prem_q};
        end
`endif
      end
      S_DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  assign q       = q_q;
  assign ovf     = ovf_q;
  assign div_err = err_q;
`ifdef MPC_DIV_REMAINDER_EN
  assign rem     = rem_q;
`endif

endmodule

// File: tb/tb_mpc_sdiv_35s_13ns_21s_seq.sv
// Directed testbench for mpc_sdiv_35s_13ns_21s_seq: a vector table plus
// hand-written sequences for clock-enable stalls, output back-pressure and
// reset during a division. Remainder checks apply when MPC_DIV_REMAINDER_EN is defined.
module tb_mpc_sdiv_35s_13ns_21s_seq;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ce = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [34:0] a = '0;
  logic        [12:0] b = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [20:0] q;
  logic               ovf;
  logic               div_err;
`ifdef MPC_DIV_REMAINDER_EN
  logic signed [13:0] rem;
`endif

  int tests = 0;
  int fails = 0;

  mpc_sdiv_35s_13ns_21s_seq dut (
    .clk(clk), .rst(rst), .ce(ce),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .ovf(ovf), .div_err(div_err)
`ifdef MPC_DIV_REMAINDER_EN
    , .rem(rem)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [34:0] a;
    logic        [12:0] b;
    logic signed [20:0] q;
    logic               ovf;
    logic               err;
    logic signed [13:0] rem;
    int                 lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge; caller guarantees ce=1 and IDLE.
  task automatic accept(input logic signed [34:0] av, input logic [12:0] bv);
    chk("in_ready_before_accept", longint'(in_ready), 1);
    a = av;
    b = bv;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 300) begin
      step();
      n++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_release", longint'(out_valid), 0);
    chk("in_ready_after_release", longint'(in_ready), 1);
  endtask

  initial begin
    int n;
    logic signed [20:0] held_q;

    vecs[0]  = '{35'sd1000, 13'd7, 21'sd142, 1'b0, 1'b0, 14'sd6, 36};
    vecs[1]  = '{-35'sd1000, 13'd7, -21'sd142, 1'b0, 1'b0, -14'sd6, 36};
    vecs[2]  = '{35'sd17179869183, 13'd1, 21'sd1048575, 1'b1, 1'b0, 14'sd0, 36};
    vecs[3]  = '{-35'sd8588886016, 13'd8191, -21'sd1048576, 1'b0, 1'b0, 14'sd0, 36};
    vecs[4]  = '{-35'sd5, 13'd0, -21'sd1048576, 1'b1, 1'b1, 14'sd0, 1};
    vecs[5]  = '{35'sd5, 13'd0, 21'sd1048575, 1'b1, 1'b1, 14'sd0, 1};
    vecs[6]  = '{35'sd1048575, 13'd1, 21'sd1048575, 1'b0, 1'b0, 14'sd0, 36};
    vecs[7]  = '{35'sd1048576, 13'd1, 21'sd1048575, 1'b1, 1'b0, 14'sd0, 36};
    vecs[8]  = '{-35'sd1048577, 13'd1, -21'sd1048576, 1'b1, 1'b0, 14'sd0, 36};
    vecs[9]  = '{35'sd0, 13'd5, 21'sd0, 1'b0, 1'b0, 14'sd0, 36};
    vecs[10] = '{-35'sd7, 13'd8191, 21'sd0, 1'b0, 1'b0, -14'sd7, 36};
    vecs[11] = '{35'sd17179869183, 13'd8191, 21'sd1048575, 1'b1, 1'b0, 14'sd255, 36};
    vecs[12] = '{35'sd49, 13'd7, 21'sd7, 1'b0, 1'b0, 14'sd0, 36};

    // Reset state.
    step();
    step();
    rst = 1'b0;
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_q", longint'(q), 0);
    chk("reset_ovf", longint'(ovf), 0);
    chk("reset_div_err", longint'(div_err), 0);
`ifdef MPC_DIV_REMAINDER_EN
    chk("reset_rem", longint'(rem), 0);
`endif

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      accept(vecs[i].a, vecs[i].b);
      wait_done(n);
      chk($sformatf("v%0d_latency", i), longint'(n), longint'(vecs[i].lat));
      chk($sformatf("v%0d_q", i), longint'(q), longint'(vecs[i].q));
      chk($sformatf("v%0d_ovf", i), longint'(ovf), longint'(vecs[i].ovf));
      chk($sformatf("v%0d_div_err", i), longint'(div_err), longint'(vecs[i].err));
`ifdef MPC_DIV_REMAINDER_EN
      chk($sformatf("v%0d_rem", i), longint'(rem), longint'(vecs[i].rem));
`endif
      release_result();
    end

    // ce low for 10 cycles mid-CALC; in_valid while busy must be ignored.
    accept(35'sd1000, 13'd7);
    a = 35'sd99;
    b = 13'd3;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 300) begin
      if (n == 10) ce = 1'b0;
      if (n == 20) ce = 1'b1;
      if (n == 25) in_valid = 1'b0;
      step();
      n++;
    end
    in_valid = 1'b0;
    chk("ce_stall_edges", longint'(n), 46);
    chk("ce_stall_q", longint'(q), 142);
`ifdef MPC_DIV_REMAINDER_EN
    chk("ce_stall_rem", longint'(rem), 6);
`endif

    // Back-pressure: result held while out_ready=0.
    held_q = q;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_out_valid", longint'(out_valid), 1);
      chk("hold_q", longint'(q), longint'(held_q));
      chk("hold_in_ready", longint'(in_ready), 0);
    end
    // out_ready with ce=0 must not consume the result.
    ce = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ce_low_done_out_valid", longint'(out_valid), 1);
    ce = 1'b1;
    out_ready = 1'b0;
    release_result();

    // Reset at iteration 20 aborts the division.
    accept(35'sd1000, 13'd7);
    for (int k = 0; k < 20; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_out_valid", longint'(out_valid), 0);
    chk("abort_q", longint'(q), 0);
    chk("abort_in_ready", longint'(in_ready), 1);
    accept(35'sd49, 13'd7);
    wait_done(n);
    chk("post_abort_latency", longint'(n), 36);
    chk("post_abort_q", longint'(q), 7);
`ifdef MPC_DIV_REMAINDER_EN
    chk("post_abort_rem", longint'(rem), 0);
`endif
    release_result();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
